// File: rtl/pair_uop_sequencer_if.sv
// ---------------------------------------------------------------------------
// pair_uop_sequencer_if : fetch-side and dispatch-side signals of the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pair_uop_sequencer_if #(
  parameter int INSNBITS_SIZE = 32
);
  logic                     in_stall;
  logic [INSNBITS_SIZE-1:0] in_fetch_insnbits;
  logic                     in_fetch_done;
  logic                     out_fetch_stall;
  logic [INSNBITS_SIZE-1:0] out_uop_insnbits;
  logic                     out_uop_done;
  logic                     out_uop_first;
  logic                     out_uop_last;
  logic                     out_uop_ofs_ovf;

  modport master (
    output in_stall, in_fetch_insnbits, in_fetch_done,
    input  out_fetch_stall, out_uop_insnbits, out_uop_done,
           out_uop_first, out_uop_last, out_uop_ofs_ovf
  );

  modport slave (
    input  in_stall, in_fetch_insnbits, in_fetch_done,
    output out_fetch_stall, out_uop_insnbits, out_uop_done,
           out_uop_first, out_uop_last, out_uop_ofs_ovf
  );
endinterface

`default_nettype wire

// File: rtl/pair_uop_sequencer.sv
// ---------------------------------------------------------------------------
// pair_uop_sequencer : cracks STP (signed offset) / LDP (post-index) into uops
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pair_uop_sequencer #(
  parameter int INSNBITS_SIZE   = 32,
  parameter int PAIR_SCALE_LOG2 = 3
) (
  input  wire logic               in_clk,
  input  wire logic               in_rst,
  pair_uop_sequencer_if.slave     bus
);

  localparam logic [10:0] c_STUR_OPC = 11'b11111000000;
  localparam logic [10:0] c_LDUR_OPC = 11'b11111000010;
  localparam logic [9:0]  c_ADD_OPC  = 10'b1001000100;
  localparam logic [9:0]  c_SUB_OPC  = 10'b1101000100;
  localparam logic [9:0]  c_STP_CLS  = 10'b1010100100;
  localparam logic [9:0]  c_LDP_CLS  = 10'b1010100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UOP1 = 2'd1,
    S_UOP2 = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [INSNBITS_SIZE-1:0] r_insn, w_insn_nxt;
  logic r_done, w_done_nxt;
  logic r_first, w_first_nxt;
  logic r_last, w_last_nxt;
  logic r_ovf, w_ovf_nxt;
  logic w_latch;

  logic        r_is_ldp;
  logic [4:0]  r_rt2;
  logic [4:0]  r_rn;
  logic [11:0] r_off;

  logic        w_accept;
  logic        w_is_stp;
  logic        w_is_ldp;
  logic [6:0]  w_imm7;
  logic [4:0]  w_rt2;
  logic [4:0]  w_rn;
  logic [4:0]  w_rt;
  logic [11:0] w_off;
  logic [11:0] w_step;
  logic [11:0] w_off1;
  logic [11:0] w_wb_imm;
  logic [INSNBITS_SIZE-1:0] w_wb_insn;

  function automatic logic [INSNBITS_SIZE-1:0] f_lsu(
    input logic [10:0] opc, input logic [11:0] off,
    input logic [4:0] rn, input logic [4:0] rt);
    f_lsu = INSNBITS_SIZE'({opc, off[8:0], 2'b00, rn, rt});
  endfunction

  function automatic logic [INSNBITS_SIZE-1:0] f_addsub(
    input logic [9:0] opc, input logic [11:0] imm, input logic [4:0] rn);
    f_addsub = INSNBITS_SIZE'({opc, imm, rn, rn});
  endfunction

  // imm9 holds -256..255 exactly when bits [11:8] are a pure sign extension
  function automatic logic f_ovf(input logic [11:0] off);
    f_ovf = ~((&off[11:8]) | ~(|off[11:8]));
  endfunction

  assign bus.out_fetch_stall  = bus.in_stall | (r_state != S_IDLE);
  assign bus.out_uop_insnbits = r_insn;
  assign bus.out_uop_done     = r_done;
  assign bus.out_uop_first    = r_first;
  assign bus.out_uop_last     = r_last;
  assign bus.out_uop_ofs_ovf  = r_ovf;

  assign w_accept = bus.in_fetch_done & ~bus.out_fetch_stall;
  assign w_is_stp = (bus.in_fetch_insnbits[31:22] == c_STP_CLS);
  assign w_is_ldp = (bus.in_fetch_insnbits[31:22] == c_LDP_CLS);
  assign w_imm7   = bus.in_fetch_insnbits[21:15];
  assign w_rt2    = bus.in_fetch_insnbits[14:10];
  assign w_rn     = bus.in_fetch_insnbits[9:5];
  assign w_rt     = bus.in_fetch_insnbits[4:0];
  assign w_off    = {{5{w_imm7[6]}}, w_imm7} << PAIR_SCALE_LOG2;
  assign w_step   = 12'(1) << PAIR_SCALE_LOG2;
  assign w_off1   = r_off + w_step;
  assign w_wb_imm = r_off[11] ? (12'd0 - r_off) : r_off;
  assign w_wb_insn = f_addsub(r_off[11] ? c_SUB_OPC : c_ADD_OPC, w_wb_imm, r_rn);

  always_comb begin
    w_state_nxt = r_state;
    w_insn_nxt  = r_insn;
    w_done_nxt  = 1'b0;
    w_first_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_done_nxt  = 1'b1;
          w_first_nxt = 1'b1;
          if (w_is_stp || w_is_ldp) begin
            w_latch     = 1'b1;
            w_state_nxt = S_UOP1;
            if (w_is_ldp) begin
              w_insn_nxt = f_lsu(c_LDUR_OPC, 12'd0, w_rn, w_rt);
            end else begin
              w_insn_nxt = f_lsu(c_STUR_OPC, w_off, w_rn, w_rt);
              w_ovf_nxt  = f_ovf(w_off);
            end
          end else begin
            w_insn_nxt = bus.in_fetch_insnbits;
            w_last_nxt = 1'b1;
          end
        end
      end
      S_UOP1: begin
        w_done_nxt = 1'b1;
        if (r_is_ldp) begin
          w_insn_nxt  = f_lsu(c_LDUR_OPC, w_step, r_rn, r_rt2);
          w_ovf_nxt   = f_ovf(w_step);
          w_state_nxt = S_UOP2;
        end else begin
          w_insn_nxt  = f_lsu(c_STUR_OPC, w_off1, r_rn, r_rt2);
          w_ovf_nxt   = f_ovf(w_off1);
          w_last_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_UOP2: begin
        w_done_nxt  = 1'b1;
        w_last_nxt  = 1'b1;
        w_insn_nxt  = w_wb_insn;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A downstream stall freezes the whole pipeline stage, fields included
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state  <= S_IDLE;
      r_insn   <= '0;
      r_done   <= 1'b0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_ovf    <= 1'b0;
      r_is_ldp <= 1'b0;
      r_rt2    <= '0;
      r_rn     <= '0;
      r_off    <= '0;
    end else if (!bus.in_stall) begin
      r_state <= w_state_nxt;
      r_insn  <= w_insn_nxt;
      r_done  <= w_done_nxt;
      r_first <= w_first_nxt;
      r_last  <= w_last_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_latch) begin
        r_is_ldp <= w_is_ldp;
        r_rt2    <= w_rt2;
        r_rn     <= w_rn;
        r_off    <= w_off;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pair_uop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pair_uop_sequencer : scoreboard bench for the pair uop sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pair_uop_sequencer;

  typedef struct packed {
    logic [31:0] insn;
    logic        first;
    logic        last;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  exp_t m_exp;
  exp_t m_got;

  pair_uop_sequencer_if #(.INSNBITS_SIZE(32)) bus ();

  pair_uop_sequencer #(.INSNBITS_SIZE(32), .PAIR_SCALE_LOG2(3)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // A uop is consumed by dispatch at the edge following a non-stalled valid cycle
  always @(negedge clk) begin
    if (!rst && bus.out_uop_done && !bus.in_stall) begin
      m_got = '{bus.out_uop_insnbits, bus.out_uop_first, bus.out_uop_last, bus.out_uop_ofs_ovf};
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL uop_unexpected: got %h f%0b l%0b o%0b, required none",
                 m_got.insn, m_got.first, m_got.last, m_got.ovf);
      end else begin
        m_exp = q.pop_front();
        if (m_got !== m_exp) begin
          n_fail++;
          $display("FAIL uop: got %h f%0b l%0b o%0b, required %h f%0b l%0b o%0b",
                   m_got.insn, m_got.first, m_got.last, m_got.ovf,
                   m_exp.insn, m_exp.first, m_exp.last, m_exp.ovf);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] insn, output int waited);
    bus.in_fetch_insnbits = insn;
    bus.in_fetch_done     = 1'b1;
    waited = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.out_fetch_stall) begin
        waited = i;
        break;
      end
    end
    n_tests++;
    if (waited < 0) begin
      n_fail++;
      $display("FAIL accept_timeout: insn %h got no accept, required accept", insn);
    end
    @(posedge clk);
    #1;
    bus.in_fetch_done = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick();
    end
  endtask

  task automatic test_reset;
    repeat (3) tick();
    n_tests++;
    if ({bus.out_uop_insnbits, bus.out_uop_done, bus.out_uop_first, bus.out_uop_last,
         bus.out_uop_ofs_ovf, bus.out_fetch_stall} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h d%0b s%0b, required 0", bus.out_uop_insnbits,
               bus.out_uop_done, bus.out_fetch_stall);
    end
    bus.in_stall = 1'b1;
    #1;
    n_tests++;
    if (bus.out_fetch_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_follow: got %0b, required 1", bus.out_fetch_stall);
    end
    bus.in_stall = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pass_through;
    int w;
    q.push_back('{32'h91000421, 1'b1, 1'b1, 1'b0});
    send(32'h91000421, w);
    n_tests++;
    if (w !== 0 || bus.out_fetch_stall !== 1'b0 || bus.out_uop_insnbits !== 32'h91000421) begin
      n_fail++;
      $display("FAIL pass_through: got wait %0d stall %0b insn %h, required 0 0 91000421",
               w, bus.out_fetch_stall, bus.out_uop_insnbits);
    end
    drain();
    tick();
    n_tests++;
    if (q.size() != 0 || bus.out_uop_done !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_idle: got pending %0d done %0b, required 0 0", q.size(), bus.out_uop_done);
    end
  endtask

  task automatic test_stp;
    int w;
    q.push_back('{32'hF8010061, 1'b1, 1'b0, 1'b0});
    q.push_back('{32'hF8018062, 1'b0, 1'b1, 1'b0});
    q.push_back('{32'h8B020020, 1'b1, 1'b1, 1'b0});
    send(32'hA9010861, w);
    n_tests++;
    if (bus.out_fetch_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stp_fetch_stall: got %0b, required 1", bus.out_fetch_stall);
    end
    send(32'h8B020020, w);
    n_tests++;
    if (w !== 1) begin
      n_fail++;
      $display("FAIL stp_next_accept: got wait %0d, required 1", w);
    end
    drain();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL stp_drain: got pending %0d, required 0", q.size());
    end
  endtask

  task automatic test_ldp;
    int w;
    logic [2:0] st;
    q.push_back('{32'hF84000C4, 1'b1, 1'b0, 1'b0});
    q.push_back('{32'hF84080C5, 1'b0, 1'b0, 1'b0});
    q.push_back('{32'hD10040C6, 1'b0, 1'b1, 1'b0});
    send(32'hA8FF14C4, w);
    st[2] = bus.out_fetch_stall;
    tick();
    st[1] = bus.out_fetch_stall;
    tick();
    st[0] = bus.out_fetch_stall;
    n_tests++;
    if (st !== 3'b110) begin
      n_fail++;
      $display("FAIL ldp_fetch_stall: got %b, required 110", st);
    end
    drain();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL ldp_drain: got pending %0d, required 0", q.size());
    end
  endtask

  task automatic test_ovf;
    int imms[5] = '{31, -32, 63, -64, 0};
    int w;
    int off;
    int rt;
    int rt2;
    int rn;
    logic [31:0] insn;
    logic [31:0] u;
    for (int i = 0; i < 5; i++) begin
      rt  = i + 1;
      rt2 = i + 10;
      rn  = i + 20;
      insn = 32'hA9000000 | 32'((imms[i] & 'h7F) << 15) | 32'(rt2 << 10) | 32'(rn << 5) | 32'(rt);
      for (int k = 0; k < 2; k++) begin
        off = imms[i] * 8 + 8 * k;
        u = 32'hF8000000 | 32'((off & 'h1FF) << 12) | 32'(rn << 5) | 32'(k == 0 ? rt : rt2);
        q.push_back('{u, (k == 0), (k == 1), (off < -256 || off > 255)});
      end
      send(insn, w);
    end
    drain();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_drain: got pending %0d, required 0", q.size());
    end
  endtask

  task automatic test_stall;
    int w;
    q.push_back('{32'hF81F8127, 1'b1, 1'b0, 1'b0});
    q.push_back('{32'hF8000128, 1'b0, 1'b1, 1'b0});
    send(32'hA93FA127, w);
    bus.in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.out_uop_insnbits !== 32'hF81F8127 || bus.out_uop_done !== 1'b1 ||
          bus.out_uop_first !== 1'b1 || bus.out_fetch_stall !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: got %h d%0b f%0b s%0b, required f81f8127 1 1 1",
                 bus.out_uop_insnbits, bus.out_uop_done, bus.out_uop_first, bus.out_fetch_stall);
      end
    end
    bus.in_stall = 1'b0;
    tick();
    n_tests++;
    if (bus.out_uop_insnbits !== 32'hF8000128 || bus.out_uop_last !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got %h l%0b, required f8000128 1",
               bus.out_uop_insnbits, bus.out_uop_last);
    end
    drain();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain: got pending %0d, required 0", q.size());
    end
  endtask

  task automatic test_back_to_back;
    int w;
    logic [31:0] insn;
    for (int i = 0; i < 4; i++) begin
      insn = $urandom;
      if (insn[31:22] == 10'b1010100100 || insn[31:22] == 10'b1010100011)
        insn[31] = 1'b0;
      q.push_back('{insn, 1'b1, 1'b1, 1'b0});
      send(insn, w);
      n_tests++;
      if (w !== 0) begin
        n_fail++;
        $display("FAIL b2b_bubble: got wait %0d, required 0", w);
      end
    end
    drain();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got pending %0d, required 0", q.size());
    end
  endtask

  task automatic test_mid_crack_reset;
    int w;
    q.push_back('{32'hF840018A, 1'b1, 1'b0, 1'b0});
    send(32'hA8C0AD8A, w);
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({bus.out_uop_insnbits, bus.out_uop_done, bus.out_uop_first, bus.out_uop_last,
         bus.out_uop_ofs_ovf, bus.out_fetch_stall} !== 37'd0) begin
      n_fail++;
      $display("FAIL midcrack_reset: got %h d%0b s%0b, required 0", bus.out_uop_insnbits,
               bus.out_uop_done, bus.out_fetch_stall);
    end
    rst = 1'b0;
    q.push_back('{32'h91000421, 1'b1, 1'b1, 1'b0});
    send(32'h91000421, w);
    n_tests++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL midcrack_resume: got wait %0d, required 0", w);
    end
    drain();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL midcrack_drain: got pending %0d, required 0", q.size());
    end
  endtask

  initial begin
    bus.in_stall          = 1'b0;
    bus.in_fetch_done     = 1'b0;
    bus.in_fetch_insnbits = '0;
    test_reset();
    test_pass_through();
    test_stp();
    test_ldp();
    test_ovf();
    test_stall();
    test_back_to_back();
    test_mid_crack_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
